record_scheduler: RTL and testbench

- Drains captured LPC records from the sniffer's record RAM and sequences them byte-by-byte to the UART transmitter.
- Owns the ring-buffer read pointer. Compares it with the producer's write pointer for empty detection, and handles producer overflow by flushing.
- Sits between the ring buffer/record RAM and uart_tx, in the single UART clock domain.

---
 rtl/lpc_sniff_pkg.sv | 17 +
 rtl/record_scheduler_if.sv | 21 ++
 rtl/record_scheduler.sv | 128 ++++++++++++
 tb/tb_record_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_sniff_pkg.sv
// rtl/lpc_sniff_pkg.sv - shared scheduler states and record-format constants for the LPC sniffer
package lpc_sniff_pkg;

    localparam int RECORD_BYTES_DEF = 6;
    localparam int SLOT_BITS_DEF    = 3;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND,
        ADVANCE,
        SYNC
    } sched_state_e;

endpackage

// File: rtl/record_scheduler_if.sv
// rtl/record_scheduler_if.sv - record RAM read port and UART byte stream seen by the scheduler
interface record_scheduler_if #(
    parameter int ADDR_W = 8
);
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output ram_en, ram_addr, tx_data, tx_valid,
        input  ram_data, tx_ready
    );

    modport slave (
        input  ram_en, ram_addr, tx_data, tx_valid,
        output ram_data, tx_ready
    );
endinterface

// File: rtl/record_scheduler.sv
// rtl/record_scheduler.sv - drains ring-buffer records from RAM to the UART one byte at a time
// Optional macro LPC_SNIFF_SYNC_EN prefixes every record with SYNC_BYTE.
module record_scheduler
    import lpc_sniff_pkg::*;
#(
    parameter int BITS         = 5,
    parameter int SLOT_BITS    = SLOT_BITS_DEF,
    parameter int RECORD_BYTES = RECORD_BYTES_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [BITS-1:0] write_ptr,
    input  logic            overflow_in,
    output logic [BITS-1:0] read_ptr,
    output logic            empty,
    output logic            overflow,
    output logic            busy,
    record_scheduler_if.master bus
);

    sched_state_e         state_q, state_d;
    logic [BITS-1:0]      read_ptr_q, read_ptr_d;
    logic [SLOT_BITS-1:0] byte_idx_q, byte_idx_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 overflow_q, overflow_d;
    logic                 flush_pending_q, flush_pending_d;
    logic                 flush_now;
    logic                 handshake;
    logic                 last_byte;

    assign empty     = (read_ptr_q == write_ptr);
    // An overflow pulse arriving in the same cycle as the flush point is honoured immediately.
    assign flush_now = flush_pending_q | overflow_in;
    assign handshake = tx_valid_q & bus.tx_ready;
    assign last_byte = (byte_idx_q == SLOT_BITS'(RECORD_BYTES - 1));

    always_comb begin
        state_d         = state_q;
        read_ptr_d      = read_ptr_q;
        byte_idx_d      = byte_idx_q;
        tx_data_d       = tx_data_q;
        tx_valid_d      = tx_valid_q;
        overflow_d      = overflow_q | overflow_in;
        flush_pending_d = flush_pending_q | overflow_in;
        case (state_q)
            IDLE: begin
                if (flush_now) begin
                    read_ptr_d      = write_ptr;
                    flush_pending_d = 1'b0;
                end else if (!empty) begin
                    byte_idx_d = '0;
`ifdef LPC_SNIFF_SYNC_EN
                    tx_data_d  = SYNC_BYTE;
                    tx_valid_d = 1'b1;
                    state_d    = SYNC;
`else
                    state_d    = FETCH;
`endif
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                tx_data_d  = bus.ram_data;
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                if (handshake) begin
                    tx_valid_d = 1'b0;
                    if (last_byte) begin
                        state_d = ADVANCE;
                    end else begin
                        byte_idx_d = byte_idx_q + SLOT_BITS'(1);
                        state_d    = FETCH;
                    end
                end
            end
            ADVANCE: begin
                if (flush_now) begin
                    read_ptr_d      = write_ptr;
                    flush_pending_d = 1'b0;
                end else begin
                    read_ptr_d = read_ptr_q + BITS'(1);
                end
                state_d = IDLE;
            end
`ifdef LPC_SNIFF_SYNC_EN
            SYNC: begin
                if (handshake) begin
                    tx_valid_d = 1'b0;
                    state_d    = FETCH;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            read_ptr_q      <= '0;
            byte_idx_q      <= '0;
            tx_data_q       <= '0;
            tx_valid_q      <= 1'b0;
            overflow_q      <= 1'b0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            read_ptr_q      <= read_ptr_d;
            byte_idx_q      <= byte_idx_d;
            tx_data_q       <= tx_data_d;
            tx_valid_q      <= tx_valid_d;
            overflow_q      <= overflow_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    assign bus.ram_en   = (state_q == FETCH);
    assign bus.ram_addr = {read_ptr_q, byte_idx_q};
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign read_ptr     = read_ptr_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_record_scheduler.sv
// tb/tb_record_scheduler.sv - self-checking bench for record_scheduler against a record-stream model
module tb_record_scheduler;
    import lpc_sniff_pkg::*;

    localparam int BITS  = 5;
    localparam int SB    = 3;
    localparam int RB    = 6;
    localparam int SLOTS = 1 << BITS;
`ifdef LPC_SNIFF_SYNC_EN
    localparam int SOFF = 1;
`else
    localparam int SOFF = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [BITS-1:0] write_ptr;
    logic            overflow_in;
    logic [BITS-1:0] read_ptr;
    logic            empty;
    logic            overflow;
    logic            busy;

    record_scheduler_if #(.ADDR_W(BITS + SB)) bus ();

    record_scheduler #(.BITS(BITS), .SLOT_BITS(SB), .RECORD_BYTES(RB)) dut (
        .clock      (clk),
        .reset      (rst),
        .write_ptr  (write_ptr),
        .overflow_in(overflow_in),
        .read_ptr   (read_ptr),
        .empty      (empty),
        .overflow   (overflow),
        .busy       (busy),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [SLOTS*8];
    always @(posedge clk) if (bus.ram_en) bus.ram_data <= mem[bus.ram_addr];

    logic [7:0] got_q[$];
    int         got_a[$];
    logic [7:0] exp_q[$];
    int         exp_a[$];

    // Inputs change just after the rising edge, so the negedge view is the value the next edge sees.
    always @(negedge clk) begin
        if (!rst && bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
        if (!rst && bus.ram_en) got_a.push_back(int'(bus.ram_addr));
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void fill_ref(input int slot);
        for (int b = 0; b < 8; b++) mem[slot*8+b] = (b < 6) ? 8'(8'h11 * (b + 1)) : 8'hFF;
    endfunction

    function automatic void fill_rand(input int slot);
        for (int b = 0; b < 8; b++) mem[slot*8+b] = 8'($urandom);
    endfunction

    function automatic void model_record(input int slot);
        if (SOFF == 1) exp_q.push_back(SYNC_BYTE);
        for (int b = 0; b < RB; b++) begin
            exp_q.push_back(mem[slot*8+b]);
            exp_a.push_back(slot*8 + b);
        end
    endfunction

    task automatic wait_idle(input string tag, input bit rnd);
        int n = 0;
        do begin
            @(posedge clk); #1;
            if (rnd) bus.tx_ready = 1'($urandom_range(0, 1));
            n++;
        end while (!(!busy && empty) && n < 3000);
        bus.tx_ready = 1'b1;
        chk({tag, "_drained"}, 32'(!busy && empty), 32'd1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i),
                (i < got_q.size()) ? 32'(got_q[i]) : 32'bx, 32'(exp_q[i]));
        chk({tag, "_nreads"}, 32'(got_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i),
                (i < got_a.size()) ? 32'(got_a[i]) : 32'bx, 32'(exp_a[i]));
        got_q.delete(); got_a.delete(); exp_q.delete(); exp_a.delete();
    endtask

    initial begin
        int stalled;
        int wp;
        int k;
        bit ok;

        rst = 1'b1; write_ptr = '0; overflow_in = 1'b0; bus.tx_ready = 1'b1;
        for (int i = 0; i < SLOTS*8; i++) mem[i] = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_empty", 32'(empty), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("idle_read_ptr", 32'(read_ptr), 32'd0);
        chk("idle_no_reads", 32'(got_a.size()), 32'd0);

        // Single record, latency from the write_ptr step.
        fill_ref(0); model_record(0);
        write_ptr = 1;
        @(posedge clk); #1;
`ifdef LPC_SNIFF_SYNC_EN
        chk("lat_sync_valid", 32'(bus.tx_valid), 32'd1);
        chk("lat_sync_data", 32'(bus.tx_data), 32'hA5);
`else
        chk("lat_n1_busy", 32'(busy), 32'd1);
        chk("lat_n1_valid", 32'(bus.tx_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_n2_valid", 32'(bus.tx_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_n3_valid", 32'(bus.tx_valid), 32'd1);
        chk("lat_n3_data", 32'(bus.tx_data), 32'h11);
`endif
        wait_idle("single", 1'b0);
        check_stream("single");
        chk("single_read_ptr", 32'(read_ptr), 32'd1);

        // Backpressure on the third data byte.
        fill_ref(1); model_record(1);
        write_ptr = 2;
        stalled = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (got_q.size() == SOFF + 2 && stalled < 10) begin
                bus.tx_ready = 1'b0;
                if (bus.tx_valid) begin
                    chk("bp_hold_data", 32'(bus.tx_data), 32'h33);
                    stalled++;
                end
            end else begin
                bus.tx_ready = 1'b1;
            end
            if (!busy && empty) break;
        end
        bus.tx_ready = 1'b1;
        chk("bp_stall_cycles", 32'(stalled), 32'd10);
        wait_idle("bp", 1'b0);
        check_stream("bp");
        chk("bp_read_ptr", 32'(read_ptr), 32'd2);

        // Reset in the middle of a record drops tx_valid without waiting for a clock.
        fill_ref(2);
        write_ptr = 3;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (bus.tx_valid) begin ok = 1'b1; break; end
        end
        chk("midrst_reached", 32'(ok), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_read_ptr", 32'(read_ptr), 32'd0);
        write_ptr = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        got_q.delete(); got_a.delete();

        // Overflow while slot 0 is in flight: slot 0 completes, slots 1..4 are skipped.
        fill_ref(0); model_record(0);
        for (int s = 1; s < 5; s++) fill_rand(s);
        write_ptr = 1;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (got_q.size() == SOFF + 1) begin ok = 1'b1; break; end
        end
        chk("ovf_reached", 32'(ok), 32'd1);
        write_ptr = 5; overflow_in = 1'b1;
        @(posedge clk); #1;
        overflow_in = 1'b0;
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_busy", 32'(busy), 32'd1);
        wait_idle("ovf", 1'b0);
        check_stream("ovf");
        chk("ovf_read_ptr", 32'(read_ptr), 32'd5);
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Idle flush to slot 31, then a record that wraps the read pointer.
        write_ptr = 31; overflow_in = 1'b1;
        @(posedge clk); #1;
        overflow_in = 1'b0;
        chk("flush_idle_rp", 32'(read_ptr), 32'd31);
        chk("flush_idle_empty", 32'(empty), 32'd1);
        fill_ref(31); model_record(31);
        write_ptr = 0;
        wait_idle("wrap", 1'b0);
        check_stream("wrap");
        chk("wrap_read_ptr", 32'(read_ptr), 32'd0);

        // Random records with random UART backpressure.
        wp = 0;
        for (int r = 0; r < 8; r++) begin
            k = $urandom_range(1, 5);
            for (int s = 0; s < k; s++) begin
                fill_rand((wp + s) % SLOTS);
                model_record((wp + s) % SLOTS);
            end
            wp = (wp + k) % SLOTS;
            write_ptr = BITS'(wp);
            wait_idle($sformatf("rnd%0d", r), 1'b1);
            check_stream($sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_read_ptr", r), 32'(read_ptr), 32'(wp));
        end

        rst = 1'b1;
        #1;
        chk("final_rst_overflow", 32'(overflow), 32'd0);
        chk("final_rst_read_ptr", 32'(read_ptr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
